// File: rtl/seq_mul_radix8_pkg.sv
// Shared constants and FSM state type for the radix-8 sequential multiplier.
// Module parameters default to the widths held here.
package seq_mul_radix8_pkg;

    localparam int unsigned A_W   = 11;
    localparam int unsigned B_W   = 12;
    localparam int unsigned DIG_W = 3;
    localparam int unsigned NDIG  = B_W / DIG_W;
    localparam int unsigned P_W   = A_W + B_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Counter width that stays legal when there is only one digit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pp_gen_x8.sv
// Radix-8 partial-product generator: operand times a 3-bit digit (0..7),
// built from the x1, x2 and x4 multiples selected by the digit bits.
module pp_gen_x8 #(
    parameter int unsigned A_W = seq_mul_radix8_pkg::A_W
) (
    input  logic [A_W-1:0] operand,
    input  logic [2:0]     digit,
    output logic [A_W+2:0] pp
);
    import seq_mul_radix8_pkg::*;

    logic [A_W+DIG_W-1:0] ext;

    assign ext = {{DIG_W{1'b0}}, operand};

    always_comb begin
        pp = '0;
        if (digit[0]) pp = pp + ext;
        if (digit[1]) pp = pp + (ext << 1);
        if (digit[2]) pp = pp + (ext << 2);
    end

endmodule

// File: rtl/seq_mul_radix8.sv
// Unsigned sequential multiplier retiring one 3-bit multiplier digit per clock,
// with a valid/ready handshake on operands and product.
module seq_mul_radix8 #(
    parameter int unsigned A_W = seq_mul_radix8_pkg::A_W,
    parameter int unsigned B_W = seq_mul_radix8_pkg::B_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+B_W-1:0] product,
    output logic               busy
);
    import seq_mul_radix8_pkg::*;

    localparam int unsigned NUM_DIG = B_W / DIG_W;
    localparam int unsigned PROD_W  = A_W + B_W;
    localparam int unsigned CNT_W   = cnt_width(NUM_DIG);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIG - 1);

    state_e state, state_next;

    logic [A_W-1:0]       a_reg;
    logic [B_W-1:0]       b_reg;
    logic [PROD_W-1:0]    acc;
    logic [CNT_W-1:0]     cnt;
    logic [DIG_W-1:0]     digit;
    logic [A_W+DIG_W-1:0] pp;
    logic [PROD_W-1:0]    pp_shifted;
    logic                 accept;
    logic                 last_dig;

    assign accept     = in_valid && (state == IDLE);
    assign last_dig   = (cnt == LAST_CNT);
    assign digit      = b_reg[DIG_W*cnt +: DIG_W];
    assign pp_shifted = PROD_W'(pp) << (DIG_W * cnt);

    pp_gen_x8 #(
        .A_W (A_W)
    ) u_pp_gen (
        .operand (a_reg),
        .digit   (digit),
        .pp      (pp)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last_dig) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        product   = acc;
    end

    // Datapath; cnt holds at the last digit and is cleared by the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc <= acc + pp_shifted;
            if (!last_dig) cnt <= cnt + 1'b1;
        end
    end

endmodule
